// File: rtl/qu_dispatch.sv
// Dispatch stage: routes decoded micro-ops by optype into an integer queue and a load/store queue.
// Optional synchronous flush port enabled by defining QU_DISPATCH_FLUSH_EN.

module qu_dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 83,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [CW-1:0]    count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             pop;

  assign valid_o = (count_q != '0);
  assign pop     = valid_o && ready_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q + CW'(push_i) - CW'(pop);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

module qu_dispatch #(
  parameter int INT_QUEUE_DEPTH  = 4,
  parameter int LDST_QUEUE_DEPTH = 4,
  parameter int UOP_WIDTH        = 83
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
`ifdef QU_DISPATCH_FLUSH_EN
  input  logic                                   flush,
`endif
  input  logic [UOP_WIDTH-1:0]                   uop_in,
  input  logic                                   uop_in_valid,
  output logic                                   uop_in_ready,
  output logic [UOP_WIDTH-1:0]                   int_uop_out,
  output logic                                   int_uop_out_valid,
  input  logic                                   int_uop_out_ready,
  output logic [UOP_WIDTH-1:0]                   ldst_uop_out,
  output logic                                   ldst_uop_out_valid,
  input  logic                                   ldst_uop_out_ready,
  output logic [$clog2(INT_QUEUE_DEPTH+1)-1:0]   int_count,
  output logic [$clog2(LDST_QUEUE_DEPTH+1)-1:0]  ldst_count,
  output logic                                   illegal_optype
);
  localparam int INT_CW  = $clog2(INT_QUEUE_DEPTH + 1);
  localparam int LDST_CW = $clog2(LDST_QUEUE_DEPTH + 1);

  typedef enum logic [3:0] {
    OP_INT    = 4'b0001,
    OP_BRANCH = 4'b0011,
    OP_CONT   = 4'b0111,
    OP_LOAD   = 4'b1001,
    OP_STORE  = 4'b0101
  } optype_e;

  logic flush_w;
`ifdef QU_DISPATCH_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  logic is_int, is_ldst, is_illegal, accept;
  logic illegal_q, illegal_d;

  always_comb begin
    is_int  = 1'b0;
    is_ldst = 1'b0;
    case (uop_in[3:0])
      OP_INT, OP_BRANCH, OP_CONT: is_int  = 1'b1;
      OP_LOAD, OP_STORE:          is_ldst = 1'b1;
      default: ;
    endcase
    is_illegal = !is_int && !is_ldst;
  end

  // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign uop_in_ready = !flush_w &&
                        (is_illegal ||
                         (is_int  && (int_count  < INT_CW'(INT_QUEUE_DEPTH))) ||
                         (is_ldst && (ldst_count < LDST_CW'(LDST_QUEUE_DEPTH))));
  assign accept    = uop_in_valid && uop_in_ready;
  assign illegal_d = accept && is_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end
  assign illegal_optype = illegal_q;

  qu_dispatch_fifo #(.DEPTH(INT_QUEUE_DEPTH), .WIDTH(UOP_WIDTH), .CW(INT_CW)) u_int_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush_w),
    .push_i  (accept && is_int),
    .data_i  (uop_in),
    .ready_i (int_uop_out_ready),
    .data_o  (int_uop_out),
    .valid_o (int_uop_out_valid),
    .count_o (int_count)
  );

  qu_dispatch_fifo #(.DEPTH(LDST_QUEUE_DEPTH), .WIDTH(UOP_WIDTH), .CW(LDST_CW)) u_ldst_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (flush_w),
    .push_i  (accept && is_ldst),
    .data_i  (uop_in),
    .ready_i (ldst_uop_out_ready),
    .data_o  (ldst_uop_out),
    .valid_o (ldst_uop_out_valid),
    .count_o (ldst_count)
  );
endmodule

// File: tb/tb_qu_dispatch.sv
// Scoreboard bench for qu_dispatch: a negedge monitor keeps per-queue expected contents,
// checks ready/valid/count/head data every cycle and pops expectations as the DUT drains.

module tb_qu_dispatch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [82:0] uop_in = '0;
  logic        uop_in_valid = 1'b0;
  logic        uop_in_ready;
  logic [82:0] int_uop_out, ldst_uop_out;
  logic        int_uop_out_valid, ldst_uop_out_valid;
  logic        int_uop_out_ready = 1'b0, ldst_uop_out_ready = 1'b0;
  logic [2:0]  int_count, ldst_count;
  logic        illegal_optype;

  int n_checks = 0;
  int n_fail   = 0;

  logic [82:0] int_exp[$];
  logic [82:0] ldst_exp[$];
  bit          exp_ill = 1'b0;

  always #5 clk = ~clk;

  qu_dispatch #(.INT_QUEUE_DEPTH(DEPTH), .LDST_QUEUE_DEPTH(DEPTH), .UOP_WIDTH(83)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
`ifdef QU_DISPATCH_FLUSH_EN
    .flush              (flush),
`endif
    .uop_in             (uop_in),
    .uop_in_valid       (uop_in_valid),
    .uop_in_ready       (uop_in_ready),
    .int_uop_out        (int_uop_out),
    .int_uop_out_valid  (int_uop_out_valid),
    .int_uop_out_ready  (int_uop_out_ready),
    .ldst_uop_out       (ldst_uop_out),
    .ldst_uop_out_valid (ldst_uop_out_valid),
    .ldst_uop_out_ready (ldst_uop_out_ready),
    .int_count          (int_count),
    .ldst_count         (ldst_count),
    .illegal_optype     (illegal_optype)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit op_is_int(input logic [3:0] op);
    return (op == 4'b0001) || (op == 4'b0011) || (op == 4'b0111);
  endfunction

  function automatic bit op_is_ldst(input logic [3:0] op);
    return (op == 4'b1001) || (op == 4'b0101);
  endfunction

  function automatic logic [82:0] mk(input logic [3:0] op, input logic [31:0] pc);
    logic [82:0] u;
    u        = '0;
    u[82:68] = 15'($urandom());
    u[67:36] = pc;
    u[35:4]  = $urandom();
    u[3:0]   = op;
    return u;
  endfunction

  // Scoreboard monitor: outputs are stable here, half a period away from the active edge.
  always @(negedge clk) begin
    logic [3:0] op;
    bit e_int, e_ldst, e_rdy, acc;
    op     = uop_in[3:0];
    e_int  = op_is_int(op);
    e_ldst = op_is_ldst(op);
    if (!rst_n) begin
      int_exp.delete();
      ldst_exp.delete();
      exp_ill = 1'b0;
      check("rst_int_valid", 96'(int_uop_out_valid), 96'(0));
      check("rst_ldst_valid", 96'(ldst_uop_out_valid), 96'(0));
      check("rst_int_count", 96'(int_count), 96'(0));
      check("rst_ldst_count", 96'(ldst_count), 96'(0));
      check("rst_illegal", 96'(illegal_optype), 96'(0));
      check("rst_ready", 96'(uop_in_ready), 96'(!flush));
    end else begin
      check("int_count", 96'(int_count), 96'(int_exp.size()));
      check("ldst_count", 96'(ldst_count), 96'(ldst_exp.size()));
      check("int_valid", 96'(int_uop_out_valid), 96'(int_exp.size() != 0));
      check("ldst_valid", 96'(ldst_uop_out_valid), 96'(ldst_exp.size() != 0));
      check("illegal_optype", 96'(illegal_optype), 96'(exp_ill));
      if (int_exp.size() != 0) begin
        check("int_data", 96'(int_uop_out), 96'(int_exp[0]));
        if (int_uop_out_ready) void'(int_exp.pop_front());
      end
      if (ldst_exp.size() != 0) begin
        check("ldst_data", 96'(ldst_uop_out), 96'(ldst_exp[0]));
        if (ldst_uop_out_ready) void'(ldst_exp.pop_front());
      end
      // Expected ready uses pre-edge occupancy (sizes before this cycle's pops took effect).
      e_rdy = !flush && ((!e_int && !e_ldst) ||
                         (e_int  && (int_count_model_pre(int_exp.size(),  int_uop_out_valid && int_uop_out_ready)  < DEPTH)) ||
                         (e_ldst && (int_count_model_pre(ldst_exp.size(), ldst_uop_out_valid && ldst_uop_out_ready) < DEPTH)));
      if (uop_in_valid) check("uop_in_ready", 96'(uop_in_ready), 96'(e_rdy));
      acc = uop_in_valid && e_rdy;
      if (acc && e_int)  int_exp.push_back(uop_in);
      if (acc && e_ldst) ldst_exp.push_back(uop_in);
      exp_ill = acc && !e_int && !e_ldst;
      if (flush) begin
        int_exp.delete();
        ldst_exp.delete();
      end
    end
  end

  // Restores the registered occupancy after the monitor has already popped this cycle's head.
  function automatic int int_count_model_pre(input int size_now, input bit popped);
    return size_now + (popped ? 1 : 0);
  endfunction

  task automatic step(input bit v, input logic [3:0] op, input logic [31:0] pc,
                      input bit ir, input bit lr);
    uop_in_valid       = v;
    uop_in             = mk(op, pc);
    int_uop_out_ready  = ir;
    ldst_uop_out_ready = lr;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0001, 32'h0, 1'b1, 1'b1);
  endtask

  logic [3:0] ops [8];

  initial begin
    ops = '{4'b0001, 4'b0011, 4'b0111, 4'b1001, 4'b0101, 4'b0000, 4'b1111, 4'b0010};
    uop_in = mk(4'b0001, 32'h0);
    uop_in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single INT push with both outputs stalled, then release.
    step(1'b1, 4'b0001, 32'h100, 1'b0, 1'b0);
    step(1'b0, 4'b0001, 32'h0, 1'b0, 1'b0);
    drain();

    // Fill integer queue, refused 5th INT, LOAD still accepted.
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0011, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b1, 4'b0001, 32'h300, 1'b0, 1'b0);
    step(1'b1, 4'b1001, 32'h304, 1'b0, 1'b0);

    // Full queue with pop and push in the same cycle: push refused, accepted next cycle.
    step(1'b1, 4'b0001, 32'h400, 1'b1, 1'b0);
    step(1'b1, 4'b0001, 32'h404, 1'b0, 1'b0);
    drain();

    // Alternating STORE/CONT stream with both consumers always ready.
    for (int i = 0; i < 10; i++)
      step(1'b1, (i % 2 == 0) ? 4'b0101 : 4'b0111, 32'h500 + 32'(4 * i), 1'b1, 1'b1);
    drain();

    // Unknown optype is swallowed and pulses illegal_optype once.
    step(1'b1, 4'b0000, 32'h600, 1'b1, 1'b1);
    step(1'b0, 4'b0000, 32'h0, 1'b1, 1'b1);
    step(1'b0, 4'b0000, 32'h0, 1'b1, 1'b1);

    // Random mix: independent back-pressure on each queue, illegal ops sprinkled in.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), ops[$urandom_range(0, 7)], 32'($urandom()),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();

    // Reset in the middle of traffic discards queued entries.
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0001, 32'h700 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b1, 4'b0000, 32'h710, 1'b0, 1'b0);
    uop_in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 4'b0001, 32'h0, 1'b0, 1'b0);

`ifdef QU_DISPATCH_FLUSH_EN
    // Flush with concurrent push and pops clears both queues.
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0001, 32'h800 + 32'(4 * i), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 4'b1001, 32'h900 + 32'(4 * i), 1'b0, 1'b0);
    flush = 1'b1;
    step(1'b1, 4'b0001, 32'h a00, 1'b1, 1'b1);
    flush = 1'b0;
    step(1'b0, 4'b0001, 32'h0, 1'b0, 1'b0);
    step(1'b0, 4'b0001, 32'h0, 1'b0, 1'b0);
`endif

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
